// File: rtl/melody_sequencer.sv
// Plays short ROM-stored melodies on request, driving piezo_ctrl enable and half-period limit.
// Latency: request sampled at edge t -> FETCH after t -> tone and new limit visible after t+1.
// Backpressure: none; requests below or equal to the playing song's id are dropped, i_stop always wins.
module melody_sequencer #(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned TICK_DIV = 5_000_000,
  parameter int unsigned GAP_CYC  = 500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  i_req,
  input  logic        i_stop,
  output logic        o_play_en,
  output logic [31:0] o_cnt_limit,
  output logic        o_busy,
  output logic [1:0]  o_song_id,
  output logic        o_done
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_NOTE, S_GAP} state_t;

  localparam logic [31:0] L_C4 = 32'(CLK_HZ / (2 * 262) - 1);
  localparam logic [31:0] L_D4 = 32'(CLK_HZ / (2 * 294) - 1);
  localparam logic [31:0] L_E4 = 32'(CLK_HZ / (2 * 330) - 1);
  localparam logic [31:0] L_F4 = 32'(CLK_HZ / (2 * 349) - 1);
  localparam logic [31:0] L_G4 = 32'(CLK_HZ / (2 * 392) - 1);
  localparam logic [31:0] L_A4 = 32'(CLK_HZ / (2 * 440) - 1);
  localparam logic [31:0] L_B4 = 32'(CLK_HZ / (2 * 494) - 1);
  localparam logic [31:0] L_C5 = 32'(CLK_HZ / (2 * 523) - 1);
  localparam logic [31:0] L_D5 = 32'(CLK_HZ / (2 * 587) - 1);
  localparam logic [31:0] L_E5 = 32'(CLK_HZ / (2 * 659) - 1);
  localparam logic [31:0] L_G5 = 32'(CLK_HZ / (2 * 784) - 1);
  localparam logic [31:0] L_A5 = 32'(CLK_HZ / (2 * 880) - 1);
  localparam logic [31:0] L_B5 = 32'(CLK_HZ / (2 * 988) - 1);

  // Melody ROM: {note, dur}; anything not listed reads as END.
  function automatic logic [7:0] rom_entry(input logic [1:0] song, input logic [3:0] idx);
    logic [7:0] e;
    e = 8'hF0;
    case ({song, idx})
      6'h00: e = 8'h12;  6'h01: e = 8'h32;  6'h02: e = 8'h52;  6'h03: e = 8'h84;
      6'h10: e = 8'h61;  6'h11: e = 8'h01;  6'h12: e = 8'h61;
      6'h20: e = 8'h31;  6'h21: e = 8'h51;  6'h22: e = 8'h83;
      6'h30: e = 8'h52;  6'h31: e = 8'h32;  6'h32: e = 8'h16;
      default: e = 8'hF0;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] note_limit(input logic [3:0] n);
    logic [31:0] l;
    l = 32'd0;
    case (n)
      4'd1: l = L_C4;   4'd2: l = L_D4;   4'd3: l = L_E4;   4'd4: l = L_F4;
      4'd5: l = L_G4;   4'd6: l = L_A4;   4'd7: l = L_B4;   4'd8: l = L_C5;
      4'd9: l = L_D5;   4'd10: l = L_E5;  4'd11: l = L_G5;  4'd12: l = L_A5;
      4'd13: l = L_B5;
      default: l = 32'd0;
    endcase
    return l;
  endfunction

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;     // bit 4 set means the index ran past 15
  logic [31:0] timer_q, timer_d;
  logic [1:0]  song_q, song_d;
  logic        play_q, play_d;
  logic [31:0] limit_q, limit_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [7:0]  rom_dat;
  logic [3:0]  note, dur, dur_eff;
  logic        is_tone, is_end;
  logic [1:0]  req_id;
  logic        req_accept;

  assign rom_dat = rom_entry(song_q, idx_q[3:0]);
  assign note    = rom_dat[7:4];
  assign dur     = rom_dat[3:0];
  assign dur_eff = (dur == 4'd0) ? 4'd1 : dur;
  assign is_end  = idx_q[4] || (note == 4'd15);
  assign is_tone = (note != 4'd0) && (note != 4'd14);

  // Fixed-priority pick of the requester; bit 3 wins.
  always_comb begin
    req_id = 2'd0;
    if (i_req[3])      req_id = 2'd3;
    else if (i_req[2]) req_id = 2'd2;
    else if (i_req[1]) req_id = 2'd1;
    else               req_id = 2'd0;
  end

  // A request starts a song when idle or when it outranks the one playing.
  assign req_accept = (|i_req) && ((state_q == S_IDLE) || (req_id > song_q));

  // State register and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 5'd0;
      timer_q <= 32'd0;
      song_q  <= 2'd0;
      play_q  <= 1'b0;
      limit_q <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      song_q  <= song_d;
      play_q  <= play_d;
      limit_q <= limit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and output logic: stop beats requests, requests beat sequencing.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    song_d  = song_q;
    play_d  = play_q;
    limit_d = limit_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (i_stop) begin
      state_d = S_IDLE;
      idx_d   = 5'd0;
      timer_d = 32'd0;
      play_d  = 1'b0;
      busy_d  = 1'b0;
    end else if (req_accept) begin
      state_d = S_FETCH;
      song_d  = req_id;
      idx_d   = 5'd0;
      timer_d = 32'd0;
      play_d  = 1'b0;
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          play_d = 1'b0;
          busy_d = 1'b0;
        end
        S_FETCH: begin
          if (is_end) begin
            state_d = S_IDLE;
            idx_d   = 5'd0;
            play_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_NOTE;
            timer_d = 32'(dur_eff) * TICK_DIV;
            play_d  = is_tone;
            if (is_tone) limit_d = note_limit(note);
          end
        end
        S_NOTE: begin
          // Enable drops in the exit cycle so piezo_ctrl sees a clean restart.
          if (timer_q <= 32'd1) begin
            play_d = 1'b0;
            if (GAP_CYC == 0) begin
              state_d = S_FETCH;
              idx_d   = idx_q + 5'd1;
              timer_d = 32'd0;
            end else begin
              state_d = S_GAP;
              timer_d = 32'(GAP_CYC);
            end
          end else begin
            timer_d = timer_q - 32'd1;
          end
        end
        S_GAP: begin
          play_d = 1'b0;
          if (timer_q <= 32'd1) begin
            state_d = S_FETCH;
            idx_d   = idx_q + 5'd1;
            timer_d = 32'd0;
          end else begin
            timer_d = timer_q - 32'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign o_play_en   = play_q;
  assign o_cnt_limit = limit_q;
  assign o_busy      = busy_q;
  assign o_song_id   = song_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboarded bench for melody_sequencer: a song-level model predicts tone segments and done pulses.
// Timing: cycle-numbered events (start edge, length) compared against what the DUT emits.
// Interrupts (stop, preemption, reset) trim the still-pending expectations of the song in flight.
module tb_melody_sequencer;
  localparam int CLK_HZ = 50_000_000;
  localparam int TICK   = 10;
  localparam int GAP    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  i_req;
  logic        i_stop;
  logic        o_play_en;
  logic [31:0] o_cnt_limit;
  logic        o_busy;
  logic [1:0]  o_song_id;
  logic        o_done;

  melody_sequencer #(.CLK_HZ(CLK_HZ), .TICK_DIV(TICK), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_stop(i_stop),
    .o_play_en(o_play_en), .o_cnt_limit(o_cnt_limit), .o_busy(o_busy),
    .o_song_id(o_song_id), .o_done(o_done)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far; values sampled at negedge are "after edge cyc".
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;   // 0 tone segment, 1 done pulse
    int song;
    int start;
    int len;
    int limit;
    int inst;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  // Songs as listed note-by-note (15 = END), durations in ticks.
  int song_note [4][5] = '{'{1, 3, 5, 8, 15}, '{6, 0, 6, 15, 15}, '{3, 5, 8, 15, 15}, '{5, 3, 1, 15, 15}};
  int song_dur  [4][5] = '{'{2, 2, 2, 4, 0},  '{1, 1, 1, 0, 0},   '{1, 1, 3, 0, 0},   '{2, 2, 6, 0, 0}};

  bit cur_valid = 0;
  int cur_song  = 0;
  int cur_end   = 0;
  int cur_inst  = 0;
  int inst_ctr  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int freq_of(input int n);
    case (n)
      1: return 262;  2: return 294;  3: return 330;  4: return 349;
      5: return 392;  6: return 440;  7: return 494;  8: return 523;
      9: return 587;  10: return 659; 11: return 784; 12: return 880;
      13: return 988;
      default: return 0;
    endcase
  endfunction

  // Expand a song into its timeline: each entry is 1 fetch + max(dur,1)*TICK play + GAP silence.
  task automatic start_song(input int id, input int t);
    ev_t e;
    int  f, n, d, len;
    inst_ctr++;
    cur_inst = inst_ctr;
    f = t;
    for (int j = 0; j < 5; j++) begin
      n = song_note[id][j];
      if (n == 15) break;
      d = song_dur[id][j];
      len = ((d == 0) ? 1 : d) * TICK;
      if (n != 0 && n != 14) begin
        e = '{kind: 0, song: id, start: f + 1, len: len,
              limit: CLK_HZ / (2 * freq_of(n)) - 1, inst: cur_inst};
        exp_q.push_back(e);
      end
      f = f + len + GAP + 1;
    end
    e = '{kind: 1, song: id, start: f + 1, len: 0, limit: 0, inst: cur_inst};
    exp_q.push_back(e);
    cur_end   = f + 1;
    cur_valid = 1;
    cur_song  = id;
  endtask

  // Song in flight is cut at edge p: nothing from edge p onward survives.
  task automatic truncate(input int p);
    ev_t e;
    while (exp_q.size() > 0) begin
      e = exp_q[exp_q.size() - 1];
      if (e.inst != cur_inst) break;
      if (e.start > p - 1) begin
        exp_q.delete(exp_q.size() - 1);
        continue;
      end
      if (e.kind == 0 && e.start + e.len > p) begin
        e.len = p - e.start;
        exp_q.delete(exp_q.size() - 1);
        exp_q.push_back(e);
      end
      break;
    end
  endtask

  // Input pattern that takes effect at edge p.
  task automatic model_apply(input logic [3:0] req, input bit stop, input bit reset, input int p);
    bit busy_m;
    int id;
    busy_m = cur_valid && (p <= cur_end);
    if (stop || reset) begin
      if (busy_m) truncate(p);
      cur_valid = 0;
      return;
    end
    if (req == 4'd0) return;
    id = req[3] ? 3 : req[2] ? 2 : req[1] ? 1 : 0;
    if (busy_m && id <= cur_song) return;
    if (busy_m) truncate(p);
    start_song(id, p);
  endtask

  // Called at a negedge; inputs are held for exactly one rising edge.
  task automatic send(input logic [3:0] req, input bit stop);
    model_apply(req, stop, 1'b0, cyc + 1);
    i_req  = req;
    i_stop = stop;
    @(negedge clk);
    i_req  = 4'd0;
    i_stop = 1'b0;
  endtask

  task automatic pop_expect(output ev_t e, output bit ok);
    ok = 1'b0;
    e  = '{kind: -1, song: -1, start: -1, len: -1, limit: -1, inst: -1};
    if (exp_q.size() == 0) begin
      check("unexpected_event", 1, 0);
    end else begin
      e  = exp_q.pop_front();
      ok = 1'b1;
    end
  endtask

  // Monitor: turns the output stream into tone segments and done pulses and scores them.
  bit          prev_play = 0;
  int          seg_start, seg_len, seg_song, seg_busy, seg_chg;
  longint      seg_lim;
  always @(negedge clk) begin
    ev_t e;
    bit  ok;
    if (o_play_en === 1'b1) begin
      if (!prev_play) begin
        seg_start = cyc;
        seg_len   = 0;
        seg_lim   = o_cnt_limit;
        seg_song  = o_song_id;
        seg_busy  = o_busy;
        seg_chg   = 0;
      end else if (o_cnt_limit != seg_lim) begin
        seg_chg = 1;
      end
      seg_len++;
    end else if (prev_play) begin
      pop_expect(e, ok);
      if (ok) begin
        check("event_kind_tone", 0, e.kind);
        check("tone_start", seg_start, e.start);
        check("tone_len", seg_len, e.len);
        check("tone_limit", seg_lim, e.limit);
        check("tone_song_id", seg_song, e.song);
        check("tone_busy", seg_busy, 1);
        check("tone_limit_stable", seg_chg, 0);
      end
    end
    prev_play = (o_play_en === 1'b1);
    if (o_done === 1'b1) begin
      pop_expect(e, ok);
      if (ok) begin
        check("event_kind_done", 1, e.kind);
        check("done_cycle", cyc, e.start);
        check("done_song_id", o_song_id, e.song);
        check("done_busy_low", o_busy, 0);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_play_en"}, o_play_en, 0);
    check({tag, "_cnt_limit"}, o_cnt_limit, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_song_id"}, o_song_id, 0);
    check({tag, "_done"}, o_done, 0);
  endtask

  initial begin
    rst    = 1'b0;
    i_req  = 4'd0;
    i_stop = 1'b0;
    #1 rst = 1'b1;
    #1 check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Song 0 start jingle, runs to completion.
    send(4'b0001, 1'b0);
    repeat (130) @(negedge clk);
    // Song 1 with a rest in the middle.
    send(4'b0010, 1'b0);
    repeat (60) @(negedge clk);
    // Song 0 preempted by song 3 in the middle of its second note.
    send(4'b0001, 1'b0);
    repeat (30) @(negedge clk);
    send(4'b1000, 1'b0);
    repeat (130) @(negedge clk);
    // Lower-priority request during song 2 is dropped, as is a same-id re-request.
    send(4'b0100, 1'b0);
    repeat (15) @(negedge clk);
    send(4'b0001, 1'b0);
    repeat (5) @(negedge clk);
    send(4'b0100, 1'b0);
    repeat (70) @(negedge clk);
    // Two requests in one cycle, then stop together with a request.
    send(4'b0110, 1'b0);
    repeat (20) @(negedge clk);
    send(4'b1000, 1'b1);
    repeat (3) @(negedge clk);
    check("stop_play_en", o_play_en, 0);
    check("stop_busy", o_busy, 0);
    repeat (10) @(negedge clk);
    // Asynchronous reset in the middle of a note, then a fresh start.
    send(4'b0001, 1'b0);
    repeat (15) @(negedge clk);
    #1;
    model_apply(4'd0, 1'b0, 1'b1, cyc + 1);
    rst = 1'b1;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send(4'b0001, 1'b0);
    repeat (130) @(negedge clk);

    // Random requests and stops at random spacing.
    for (int k = 0; k < 60; k++) begin
      int r;
      repeat ($urandom_range(0, 50)) @(negedge clk);
      r = $urandom_range(0, 99);
      if (r < 10) send(4'($urandom_range(0, 15)), 1'b1);
      else        send(4'($urandom_range(1, 15)), 1'b0);
    end

    repeat (200) @(negedge clk);
    check("exp_queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
